// File: rtl/semaforo_pkg.sv
// Shared definitions for the traffic-light input conditioning slice:
// channel indices into the raw sensor/button vector and its packed type.
package semaforo_pkg;

   localparam int CH_TA  = 0;
   localparam int CH_TB  = 1;
   localparam int CH_P   = 2;
   localparam int CH_R   = 3;
   localparam int NUM_CH = 4;

   typedef logic [NUM_CH-1:0] sensor_t;

endpackage : semaforo_pkg

// File: rtl/semaforo_debounce.sv
// One input channel: multi-flop synchronizer, persistence counter and accepted (stable) level.
// rise flags the edge on which the stable level is about to go 0->1, so a register fed by it lines up with level.
module semaforo_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic busy
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_r;
   logic [CNT_W-1:0]       cnt_r;
   logic                   stable_r;
   logic                   sync_s;
   logic                   accept_s;

   assign sync_s   = sync_r[SYNC_STAGES-1];
   assign accept_s = (sync_s != stable_r) && (cnt_r == CNT_MAX);

   // Synchronizer chain: bit 0 samples the asynchronous input
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= {SYNC_STAGES{1'b0}};
      end else begin
         sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
      end
   end

   // Persistence counter and stable level; any return to the stable value restarts the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r    <= {CNT_W{1'b0}};
         stable_r <= 1'b0;
      end else if (sync_s == stable_r) begin
         cnt_r    <= {CNT_W{1'b0}};
      end else if (cnt_r == CNT_MAX) begin
         stable_r <= sync_s;
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         cnt_r    <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign level = stable_r;
   assign rise  = accept_s & sync_s;
   assign busy  = (cnt_r != {CNT_W{1'b0}});

endmodule : semaforo_debounce

// File: rtl/semaforo_input_cond.sv
// Input conditioning ahead of the traffic-light controller: TA/TB as debounced levels,
// P/R as registered one-cycle rising-edge pulses, R winning when both rise together.
module semaforo_input_cond
   import semaforo_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  sensor_t raw_in,
   output logic    ta,
   output logic    tb,
   output logic    p_pulse,
   output logic    r_pulse,
   output logic    busy
);

   sensor_t level_s;
   sensor_t rise_s;
   sensor_t busy_s;
   logic    p_pulse_r;
   logic    r_pulse_r;
   logic    unused_s;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      semaforo_debounce #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk   (clk),
         .rst   (rst),
         .raw   (raw_in[i]),
         .level (level_s[i]),
         .rise  (rise_s[i]),
         .busy  (busy_s[i])
      );
   end

   // Pulse registers; a simultaneous P rise is dropped so the controller never sees both
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_pulse_r <= 1'b0;
         r_pulse_r <= 1'b0;
      end else begin
         p_pulse_r <= rise_s[CH_P] & ~rise_s[CH_R];
         r_pulse_r <= rise_s[CH_R];
      end
   end

   assign ta       = level_s[CH_TA];
   assign tb       = level_s[CH_TB];
   assign p_pulse  = p_pulse_r;
   assign r_pulse  = r_pulse_r;
   assign busy     = |busy_s;
   assign unused_s = ^{level_s[CH_P], level_s[CH_R], rise_s[CH_TA], rise_s[CH_TB]};

endmodule : semaforo_input_cond

// File: tb/tb_semaforo_input_cond.sv
// Self-checking bench for semaforo_input_cond: directed scenarios plus random toggling,
// compared every cycle against a window-based reference of the debounce rules.
module tb_semaforo_input_cond;

   localparam int SS = 2;
   localparam int DC = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] raw_in = 4'b1111;
   logic       ta, tb, p_pulse, r_pulse, busy;

   int errors = 0;
   int checks = 0;

   // reference model state
   logic [3:0] hist[$];
   logic [3:0] m_stable;
   logic       m_busy, m_p, m_r;

   // per-segment statistics
   int seg_edge, cnt_ta_hi, cnt_tb_hi, cnt_p, cnt_r, cnt_busy;
   int first_ta_hi, first_ta_lo, first_tb_hi, first_p, first_r;

   semaforo_input_cond #(
      .SYNC_STAGES     (SS),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .raw_in  (raw_in),
      .ta      (ta),
      .tb      (tb),
      .p_pulse (p_pulse),
      .r_pulse (r_pulse),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic void model_reset();
      hist.delete();
      for (int i = 0; i < SS + DC; i++) hist.push_back(4'b0000);
      m_stable = 4'b0000;
      m_busy   = 1'b0;
      m_p      = 1'b0;
      m_r      = 1'b0;
   endfunction

   // A channel flips when its last DC synchronized samples all differ from the accepted value.
   function automatic void model_edge(input logic [3:0] v);
      int         n;
      logic       flip;
      logic [3:0] rose;
      hist.push_back(v);
      n      = hist.size();
      rose   = 4'b0000;
      m_busy = 1'b0;
      for (int ch = 0; ch < 4; ch++) begin
         flip = 1'b1;
         for (int j = 0; j < DC; j++)
            if (hist[n-1-SS-j][ch] == m_stable[ch]) flip = 1'b0;
         rose[ch] = flip & ~m_stable[ch];
         if (flip) m_stable[ch] = ~m_stable[ch];
         if (hist[n-1-SS][ch] != m_stable[ch]) m_busy = 1'b1;
      end
      m_r = rose[3];
      m_p = rose[2] & ~rose[3];
      if (hist.size() > 64) void'(hist.pop_front());
   endfunction

   function automatic void clear_stats();
      seg_edge = 0; cnt_ta_hi = 0; cnt_tb_hi = 0; cnt_p = 0; cnt_r = 0; cnt_busy = 0;
      first_ta_hi = 0; first_ta_lo = 0; first_tb_hi = 0; first_p = 0; first_r = 0;
   endfunction

   task automatic tick(input logic [3:0] v);
      raw_in = v;
      @(posedge clk);
      model_edge(v);
      #2;
      check_eq("ta", {31'b0, ta}, {31'b0, m_stable[0]});
      check_eq("tb", {31'b0, tb}, {31'b0, m_stable[1]});
      check_eq("p_pulse", {31'b0, p_pulse}, {31'b0, m_p});
      check_eq("r_pulse", {31'b0, r_pulse}, {31'b0, m_r});
      check_eq("busy", {31'b0, busy}, {31'b0, m_busy});
      seg_edge++;
      if (ta) begin
         cnt_ta_hi++;
         if (first_ta_hi == 0) first_ta_hi = seg_edge;
      end else if (first_ta_lo == 0) first_ta_lo = seg_edge;
      if (tb) begin
         cnt_tb_hi++;
         if (first_tb_hi == 0) first_tb_hi = seg_edge;
      end
      if (p_pulse) begin
         cnt_p++;
         if (first_p == 0) first_p = seg_edge;
      end
      if (r_pulse) begin
         cnt_r++;
         if (first_r == 0) first_r = seg_edge;
      end
      if (busy) cnt_busy++;
   endtask

   task automatic run(input logic [3:0] v, input int n);
      for (int k = 0; k < n; k++) tick(v);
   endtask

   task automatic do_reset(input int n_edges);
      rst = 1'b1;
      #1;
      check_eq("rst_ta", {31'b0, ta}, 32'd0);
      check_eq("rst_tb", {31'b0, tb}, 32'd0);
      check_eq("rst_p", {31'b0, p_pulse}, 32'd0);
      check_eq("rst_r", {31'b0, r_pulse}, 32'd0);
      check_eq("rst_busy", {31'b0, busy}, 32'd0);
      repeat (n_edges) @(posedge clk);
      #2;
      rst = 1'b0;
      model_reset();
      clear_stats();
   endtask

   initial begin
      logic [3:0] v;
      model_reset();
      clear_stats();

      // reset with all inputs high, checked before the first clock edge
      #1;
      do_reset(2);
      run(4'b0000, 20);
      check_eq("idle_ta_hi", cnt_ta_hi, 0);
      check_eq("idle_busy", cnt_busy, 0);

      // TA latency on rise and fall
      clear_stats();
      run(4'b0001, 10);
      check_eq("ta_rise_edge", first_ta_hi, 6);
      clear_stats();
      run(4'b0000, 10);
      check_eq("ta_fall_edge", first_ta_lo, 6);

      // TB glitch of 3 cycles is rejected, 4 cycles is accepted
      clear_stats();
      run(4'b0010, 3);
      run(4'b0000, 10);
      check_eq("tb_glitch_hi", cnt_tb_hi, 0);
      check_eq("tb_glitch_busy", cnt_busy, 3);
      clear_stats();
      run(4'b0010, 4);
      run(4'b0000, 10);
      check_eq("tb_pulse_len", cnt_tb_hi, 4);
      check_eq("tb_pulse_edge", first_tb_hi, 6);

      // P held, released, then a bounce train settling high
      clear_stats();
      run(4'b0100, 20);
      check_eq("p_hold_edge", first_p, 6);
      run(4'b0000, 10);
      check_eq("p_hold_count", cnt_p, 1);
      clear_stats();
      for (int k = 0; k < 10; k++) tick(((k / 2) % 2 == 0) ? 4'b0100 : 4'b0000);
      run(4'b0100, 12);
      check_eq("p_bounce_count", cnt_p, 1);
      run(4'b0000, 10);

      // P and R rise together
      clear_stats();
      run(4'b1100, 12);
      check_eq("pr_r_edge", first_r, 6);
      check_eq("pr_r_count", cnt_r, 1);
      check_eq("pr_p_count", cnt_p, 0);
      run(4'b0000, 10);

      // reset in the middle of a TA debounce
      clear_stats();
      run(4'b0001, 4);
      do_reset(2);
      run(4'b0001, 10);
      check_eq("ta_after_rst_edge", first_ta_hi, 6);
      run(4'b0000, 10);

      // random slow toggling on all channels
      v = 4'b0000;
      for (int c = 0; c < 400; c++) begin
         for (int b = 0; b < 4; b++)
            if ($urandom_range(4, 0) == 0) v[b] = ~v[b];
         tick(v);
         check_eq("p_r_exclusive", {31'b0, p_pulse & r_pulse}, 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_semaforo_input_cond
